// File: rtl/serial_pkg.sv
// Shared 8N1 frame definitions for the serial receiver and transmitter.
package serial_pkg;

    // Receiver/transmitter state encoding (3 bits).
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; both reset to RST_VAL so reset release is glitch-free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: centre-sampled bits, start-glitch rejection, one strobe per frame.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge on the synchronised rx
//   START_BIT | counting to mid start bit; high there means a glitch
//   DATA      | sampling eight data bits LSB first at each bit centre
//   STOP_BIT  | sampling the stop bit; high -> new byte, low -> frame error
//   WAIT_HIGH | after a framing error, wait for the line to go idle again
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_new_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int H        = CLK_PER_BIT / 2;

    localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(H - 1);
    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;

    state_t               r_state;
    logic [CTR_SIZE-1:0]  r_ctr;
    logic [BIT_W-1:0]     r_bit_ctr;
    logic [7:0]           r_data_sh;
    logic [7:0]           r_data;
    logic                 r_new_data;
    logic                 r_frame_err;

    state_t               w_state_nxt;
    logic [CTR_SIZE-1:0]  w_ctr_nxt;
    logic [BIT_W-1:0]     w_bit_ctr_nxt;
    logic [7:0]           w_data_sh_nxt;
    logic [7:0]           w_data_nxt;
    logic                 w_new_data_nxt;
    logic                 w_frame_err_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ctr       <= '0;
            r_bit_ctr   <= '0;
            r_data_sh   <= 8'h00;
            r_data      <= 8'h00;
            r_new_data  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ctr       <= w_ctr_nxt;
            r_bit_ctr   <= w_bit_ctr_nxt;
            r_data_sh   <= w_data_sh_nxt;
            r_data      <= w_data_nxt;
            r_new_data  <= w_new_data_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and datapath decisions, all taken from the synchronised rx.
    always_comb begin
        w_state_nxt     = r_state;
        w_ctr_nxt       = r_ctr;
        w_bit_ctr_nxt   = r_bit_ctr;
        w_data_sh_nxt   = r_data_sh;
        w_data_nxt      = r_data;
        w_new_data_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctr_nxt     = '0;
                w_bit_ctr_nxt = '0;
                if (!w_rx_s) begin
                    // The detect cycle already counts as the first start-bit cycle.
                    w_state_nxt = START_BIT;
                    w_ctr_nxt   = CTR_SIZE'(1);
                end
            end
            START_BIT: begin
                if (r_ctr == HALF_LAST) begin
                    w_ctr_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end else begin
                    w_ctr_nxt = r_ctr + CTR_SIZE'(1);
                end
            end
            DATA: begin
                if (r_ctr == BIT_LAST) begin
                    w_ctr_nxt                = '0;
                    w_data_sh_nxt[r_bit_ctr] = w_rx_s;
                    w_bit_ctr_nxt            = r_bit_ctr + BIT_W'(1);
                    if (r_bit_ctr == LAST_BIT) begin
                        w_state_nxt = STOP_BIT;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + CTR_SIZE'(1);
                end
            end
            STOP_BIT: begin
                if (r_ctr == BIT_LAST) begin
                    w_ctr_nxt = '0;
                    if (w_rx_s == STOP_LEVEL) begin
                        w_data_nxt     = r_data_sh;
                        w_new_data_nxt = 1'b1;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = WAIT_HIGH;
                    end
                end else begin
                    w_ctr_nxt = r_ctr + CTR_SIZE'(1);
                end
            end
            WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_new_data  = r_new_data;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: table-driven frames plus hand-written corner cases,
// with a scoreboard of expected strobes (kind, data, exact cycle) per receiver instance.
module tb_serial_rx;

    localparam int CPB_A = 50;
    localparam int CPB_B = 5;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         hold;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       new_a, new_b, ferr_a, ferr_b, busy_a, busy_b;

    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tbl[6];

    serial_rx #(.CLK_PER_BIT(CPB_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_a),
        .o_data(data_a), .o_new_data(new_a), .o_frame_err(ferr_a), .o_busy(busy_a)
    );

    serial_rx #(.CLK_PER_BIT(CPB_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_b),
        .o_data(data_b), .o_new_data(new_b), .o_frame_err(ferr_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // Caller must be at a negedge; returns at the negedge that ends the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                              input logic exp_err, input logic [7:0] exp_data);
        int   cpb;
        exp_t e;
        cpb = sel ? CPB_B : CPB_A;
        set_rx(sel, 1'b0);
        e.is_err = exp_err;
        e.data   = exp_data;
        e.cyc    = cyc + 1 + cpb / 2 + 1 + 9 * cpb;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_rx(sel, stop);
        repeat (cpb) @(negedge clk);
    endtask

    // Scoreboard monitors: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (new_a || ferr_a)) begin
            check("excl_a", {31'd0, new_a & ferr_a}, 32'd0);
            if (q_a.size() == 0) begin
                check("unexpected_pulse_a", {31'd0, ferr_a}, 32'hDEAD);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("kind_a", {31'd0, ferr_a}, {31'd0, e.is_err});
                check("data_a", {24'd0, data_a}, {24'd0, e.data});
                check("latency_a", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (new_b || ferr_b)) begin
            check("excl_b", {31'd0, new_b & ferr_b}, 32'd0);
            if (q_b.size() == 0) begin
                check("unexpected_pulse_b", {31'd0, ferr_b}, 32'hDEAD);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("kind_b", {31'd0, ferr_b}, {31'd0, e.is_err});
                check("data_b", {24'd0, data_b}, {24'd0, e.data});
                check("latency_b", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;

        tbl[0] = '{8'hA5, 1'b1, 0,   20, 1'b0, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 300, 20, 1'b1, 8'hA5};
        tbl[2] = '{8'h01, 1'b1, 0,   20, 1'b0, 8'h01};
        tbl[3] = '{8'h00, 1'b1, 0,   0,  1'b0, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 0,   0,  1'b0, 8'hFF};
        tbl[5] = '{8'h55, 1'b1, 0,   10, 1'b0, 8'h55};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_new",  {31'd0, new_a},  32'd0);
        check("rst_ferr", {31'd0, ferr_a}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);
        check("post_rst_busy_b", {31'd0, busy_b}, 32'd0);

        // Table-driven frames: good byte, framing error with held break, recovery, back-to-back
        for (int i = 0; i < 6; i++) begin
            send_frame(1'b0, tbl[i].b, tbl[i].stop, tbl[i].exp_err, tbl[i].exp_data);
            if (tbl[i].hold > 0) begin
                repeat (tbl[i].hold) @(negedge clk);
                check("wait_high_busy", {31'd0, busy_a}, 32'd1);
                rx_a = 1'b1;
            end
            repeat (tbl[i].gap) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("data_after_table", {24'd0, data_a}, 32'h55);
        check("idle_after_table", {31'd0, busy_a}, 32'd0);

        // Start-bit glitch: 10 cycles low, then high; no strobe, busy drops at mid start bit
        rx_a = 1'b0;
        e0 = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        check("glitch_busy_pre", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        check("glitch_busy_set", {31'd0, busy_a}, 32'd1);
        repeat (e0 + 9 - cyc) @(negedge clk);
        rx_a = 1'b1;
        repeat (e0 + CPB_A / 2 - cyc) @(negedge clk);
        check("glitch_busy_hold", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        check("glitch_busy_drop", {31'd0, busy_a}, 32'd0);
        repeat (20) @(negedge clk);
        check("glitch_data_kept", {24'd0, data_a}, 32'h55);

        // Reset during DATA bit 3
        rx_a = 1'b0;
        e0 = cyc + 1;
        repeat (e0 + CPB_A / 2 + 1 + 3 * CPB_A + 10 - cyc) @(negedge clk);
        check("mid_frame_busy", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", {24'd0, data_a}, 32'd0);
        check("async_rst_busy", {31'd0, busy_a}, 32'd0);
        check("async_rst_new",  {31'd0, new_a},  32'd0);
        rx_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(1'b0, 8'h81, 1'b1, 1'b0, 8'h81);
        repeat (20) @(negedge clk);

        // Loopback-style sweep at CLK_PER_BIT=50, stepped values, back-to-back
        for (int v = 0; v < 256; v += 17) begin
            send_frame(1'b0, 8'(v), 1'b1, 1'b0, 8'(v));
        end
        repeat (20) @(negedge clk);

        // All 256 byte values at CLK_PER_BIT=5, back-to-back
        for (int v = 0; v < 256; v++) begin
            send_frame(1'b1, 8'(v), 1'b1, 1'b0, 8'(v));
        end
        repeat (20) @(negedge clk);

        check("scoreboard_a_drained", q_a.size(), 32'd0);
        check("scoreboard_b_drained", q_b.size(), 32'd0);
        check("final_data_b", {24'd0, data_b}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
